// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT job scheduler and its beat framer.
//   feed_state_t  : admission/feed FSM states
//   drain_state_t : output framing FSM states
//   ERR_*         : bit positions inside the sticky error vector
package ntt_pkg;

  typedef enum logic {F_IDLE = 1'b0, F_FEED = 1'b1} feed_state_t;
  typedef enum logic {D_IDLE = 1'b0, D_DRAIN = 1'b1} drain_state_t;

  localparam int unsigned ERR_MISMATCH = 0;
  localparam int unsigned ERR_CREDIT   = 1;
  localparam int unsigned ERR_SPURIOUS = 2;
  localparam int unsigned ERR_TIMEOUT  = 3;
  localparam int unsigned ERR_W        = 4;

  localparam int unsigned BEATS_PER_POLY_DEFAULT = 64;

endpackage

// File: rtl/ntt_beat_framer.sv
// Frames one polynomial worth of result beats after an accepted start strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : accepted result-start (caller has already filtered spurious strobes)
//   out_valid  : high for exactly BEATS cycles per start
//   out_sop    : first beat of a frame
//   out_eop    : last beat of a frame
//   can_start  : a start this cycle would be honoured (idle, or on the last beat)
module ntt_beat_framer
  import ntt_pkg::*;
#(
  parameter int unsigned BEATS = BEATS_PER_POLY_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic out_valid,
  output logic out_sop,
  output logic out_eop,
  output logic can_start
);

  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  drain_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= D_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      D_IDLE: begin
        if (start) begin
          state_d = D_DRAIN;
          cnt_d   = '0;
        end
      end
      D_DRAIN: begin
        if (cnt_q == LAST) begin
          // A start on the eop beat chains straight into the next frame.
          if (start) cnt_d = '0;
          else       state_d = D_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  assign out_valid = (state_q == D_DRAIN);
  assign out_sop   = out_valid && (cnt_q == '0);
  assign out_eop   = out_valid && (cnt_q == LAST);
  assign can_start = !out_valid || (cnt_q == LAST);

endmodule

// File: rtl/ntt_job_scheduler.sv
// Admits whole-polynomial jobs into a non-stallable NTT pipeline using credits,
// strobes the pipeline start, frames results and raises sticky protocol errors.
//   job_valid/job_ready : job handshake (accept when both high)
//   src_rd              : upstream presents the next beat this cycle
//   ntt_in_start        : start strobe replicas to NTT_Top
//   ntt_out_start       : result-start replicas from NTT_Top (bit 0 authoritative)
//   out_valid/sop/eop   : result framing
//   credit_ret          : downstream freed one result slot
//   inflight            : jobs accepted but not yet output-started
//   busy                : feeding, draining, or jobs in flight
//   err_clr / err       : clear / sticky {timeout, spurious_out, credit_ovf, strobe_mismatch}
module ntt_job_scheduler
  import ntt_pkg::*;
#(
  parameter int unsigned BEATS_PER_POLY = BEATS_PER_POLY_DEFAULT,
  parameter int unsigned NUM_STAGES     = 11,
  parameter int unsigned MAX_INFLIGHT   = 4,
  parameter int unsigned NTT_LATENCY    = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 job_valid,
  output logic                                 job_ready,
  output logic                                 src_rd,
  output logic [NUM_STAGES-1:0]                ntt_in_start,
  input  logic [NUM_STAGES-1:0]                ntt_out_start,
  output logic                                 out_valid,
  output logic                                 out_sop,
  output logic                                 out_eop,
  input  logic                                 credit_ret,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
  output logic                                 busy,
  input  logic                                 err_clr,
  output logic [ERR_W-1:0]                     err
);

  localparam int unsigned BW = $clog2(BEATS_PER_POLY);
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned WW = $clog2(2 * NTT_LATENCY + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_POLY - 1);
  localparam logic [IW-1:0] CRED_MAX  = IW'(MAX_INFLIGHT);
  localparam logic [WW-1:0] WD_LIMIT  = WW'(2 * NTT_LATENCY);

  feed_state_t      feed_q, feed_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [IW-1:0]    credits_q, credits_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic [ERR_W-1:0] err_q, err_d, err_evt;
  // Holds admission off while in reset and for the first cycle after release,
  // so every output reads 0 whenever rst_n is low.
  logic             run_q;

  logic accept, in_start, out_ok, can_start, drain_active, credit_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feed_q     <= F_IDLE;
      beat_q     <= '0;
      credits_q  <= CRED_MAX;
      inflight_q <= '0;
      wd_q       <= '0;
      err_q      <= '0;
      run_q      <= 1'b0;
    end else begin
      feed_q     <= feed_d;
      beat_q     <= beat_d;
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      run_q      <= 1'b1;
    end
  end

  // Feed FSM. An accept from IDLE is beat 0 itself; an accept on the last beat
  // of a job makes the following cycle beat 0, which is where in_start fires.
  always_comb begin
    feed_d    = feed_q;
    beat_d    = beat_q;
    job_ready = 1'b0;
    src_rd    = 1'b0;
    in_start  = 1'b0;
    unique case (feed_q)
      F_IDLE: begin
        job_ready = run_q && (credits_q != '0);
        if (job_valid && job_ready) begin
          feed_d   = F_FEED;
          beat_d   = BW'(1);
          src_rd   = 1'b1;
          in_start = 1'b1;
        end
      end
      F_FEED: begin
        src_rd   = 1'b1;
        in_start = (beat_q == '0);
        if (beat_q == BEAT_LAST) begin
          job_ready = (credits_q != '0);
          if (job_valid && job_ready) beat_d = '0;
          else                        feed_d = F_IDLE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
    endcase
  end

  assign accept       = job_valid && job_ready;
  assign ntt_in_start = {NUM_STAGES{in_start}};

  // Result-start qualification: bit 0 governs, the other replicas only check it.
  assign out_ok = ntt_out_start[0] && (inflight_q != '0) && can_start;

  always_comb begin
    credits_d  = credits_q;
    credit_ovf = 1'b0;
    if (accept && !credit_ret) begin
      credits_d = credits_q - IW'(1);
    end else if (credit_ret && !accept) begin
      if (credits_q == CRED_MAX) credit_ovf = 1'b1;
      else                       credits_d  = credits_q + IW'(1);
    end

    inflight_d = inflight_q;
    if (accept && !out_ok) begin
      if (inflight_q != '1) inflight_d = inflight_q + IW'(1);
    end else if (out_ok && !accept) begin
      inflight_d = inflight_q - IW'(1);
    end

    // Counting on the next-state value makes the count equal to cycles since accept.
    wd_d = wd_q;
    if ((inflight_d == '0) || out_ok) wd_d = '0;
    else if (wd_q != WD_LIMIT)        wd_d = wd_q + WW'(1);

    err_evt               = '0;
    err_evt[ERR_MISMATCH] = (ntt_out_start != {NUM_STAGES{ntt_out_start[0]}});
    err_evt[ERR_CREDIT]   = credit_ovf;
    err_evt[ERR_SPURIOUS] = ntt_out_start[0] && !out_ok;
    err_evt[ERR_TIMEOUT]  = (wd_q != WD_LIMIT) && (wd_d == WD_LIMIT);

    err_d = (err_clr ? '0 : err_q) | err_evt;
  end

  ntt_beat_framer #(
    .BEATS (BEATS_PER_POLY)
  ) u_framer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (out_ok),
    .out_valid (drain_active),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .can_start (can_start)
  );

  assign out_valid = drain_active;
  assign inflight  = inflight_q;
  assign busy      = (feed_q != F_IDLE) || drain_active || (inflight_q != '0);
  assign err       = err_q;

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Directed, table-driven bench for ntt_job_scheduler (64 beats, 4 credits, latency 1024).
module tb_ntt_job_scheduler;

  localparam int unsigned BEATS = 64;
  localparam int unsigned NS    = 11;
  localparam int unsigned MAXI  = 4;
  localparam int unsigned LAT   = 1024;
  localparam int unsigned IW    = $clog2(MAXI + 1);

  localparam int M_RDY = 1, M_SRC = 2, M_STA = 4, M_VAL = 8, M_SOP = 16;
  localparam int M_EOP = 32, M_BSY = 64, M_INF = 128, M_ERR = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          job_valid, job_ready, src_rd;
  logic [NS-1:0] ntt_in_start, ntt_out_start;
  logic          out_valid, out_sop, out_eop, credit_ret, busy, err_clr;
  logic [IW-1:0] inflight;
  logic [3:0]    err;

  ntt_job_scheduler #(
    .BEATS_PER_POLY (BEATS),
    .NUM_STAGES     (NS),
    .MAX_INFLIGHT   (MAXI),
    .NTT_LATENCY    (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .src_rd        (src_rd),
    .ntt_in_start  (ntt_in_start),
    .ntt_out_start (ntt_out_start),
    .out_valid     (out_valid),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .credit_ret    (credit_ret),
    .inflight      (inflight),
    .busy          (busy),
    .err_clr       (err_clr),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic          jv;
    logic [NS-1:0] os;
    logic          cr;
    logic          ec;
    int            m;
    logic          rdy, src, sta, val, sop, eop, bsy;
    int            inf;
    logic [3:0]    er;
  } vec_t;

  vec_t vt[$];
  int   errors = 0;
  int   checks = 0;
  logic jv_hold = 1'b0;
  int   n_src, first_src, last_src, n_val, first_val, last_val;
  int   starts[$];
  logic [NS-1:0] os_all, os_b5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input int c, input logic jv, input logic [NS-1:0] os,
                             input logic cr, input logic ec, input int m,
                             input logic rdy, input logic src, input logic sta,
                             input logic val, input logic sop, input logic eop,
                             input logic bsy, input int inf, input logic [3:0] er);
    vec_t r;
    r.cyc = c; r.jv = jv; r.os = os; r.cr = cr; r.ec = ec; r.m = m;
    r.rdy = rdy; r.src = src; r.sta = sta; r.val = val; r.sop = sop; r.eop = eop;
    r.bsy = bsy; r.inf = inf; r.er = er;
    return r;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " job_ready"}, job_ready, 0);
    chk({tag, " src_rd"}, src_rd, 0);
    chk({tag, " ntt_in_start"}, ntt_in_start, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_sop"}, out_sop, 0);
    chk({tag, " out_eop"}, out_eop, 0);
    chk({tag, " inflight"}, inflight, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " err"}, err, 0);
  endtask

  // Holds reset with job_valid asserted, checks outputs, releases between edges
  // and returns at cycle 0 (1 time unit after a rising edge).
  task automatic do_reset(input string tag);
    job_valid = 1'b1; ntt_out_start = '0; credit_ret = 1'b0; err_clr = 1'b0;
    rst_n = 1'b0;
    #17;
    check_zero(tag);
    rst_n = 1'b1;
    job_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic run_table(input string tag, input int ncyc);
    logic [NS-1:0] exp_sta;
    string p;
    n_src = 0; first_src = -1; last_src = -1;
    n_val = 0; first_val = -1; last_val = -1;
    starts.delete();
    for (int c = 0; c < ncyc; c++) begin
      int idx;
      idx = -1;
      job_valid = jv_hold; ntt_out_start = '0; credit_ret = 1'b0; err_clr = 1'b0;
      foreach (vt[i]) if (vt[i].cyc == c) idx = i;
      if (idx >= 0) begin
        job_valid = vt[idx].jv; ntt_out_start = vt[idx].os;
        credit_ret = vt[idx].cr; err_clr = vt[idx].ec;
      end
      #1;
      if (src_rd) begin n_src++; if (first_src < 0) first_src = c; last_src = c; end
      if (out_valid) begin n_val++; if (first_val < 0) first_val = c; last_val = c; end
      if (ntt_in_start != '0) starts.push_back(c);
      if (idx >= 0) begin
        p = $sformatf("%s c%0d", tag, c);
        exp_sta = {NS{vt[idx].sta}};
        if ((vt[idx].m & M_RDY) != 0) chk({p, " job_ready"}, job_ready, vt[idx].rdy);
        if ((vt[idx].m & M_SRC) != 0) chk({p, " src_rd"}, src_rd, vt[idx].src);
        if ((vt[idx].m & M_STA) != 0) chk({p, " ntt_in_start"}, ntt_in_start, exp_sta);
        if ((vt[idx].m & M_VAL) != 0) chk({p, " out_valid"}, out_valid, vt[idx].val);
        if ((vt[idx].m & M_SOP) != 0) chk({p, " out_sop"}, out_sop, vt[idx].sop);
        if ((vt[idx].m & M_EOP) != 0) chk({p, " out_eop"}, out_eop, vt[idx].eop);
        if ((vt[idx].m & M_BSY) != 0) chk({p, " busy"}, busy, vt[idx].bsy);
        if ((vt[idx].m & M_INF) != 0) chk({p, " inflight"}, inflight, vt[idx].inf);
        if ((vt[idx].m & M_ERR) != 0) chk({p, " err"}, err, vt[idx].er);
      end
      @(posedge clk); #1;
    end
    job_valid = 1'b0; ntt_out_start = '0; credit_ret = 1'b0; err_clr = 1'b0;
    jv_hold = 1'b0;
    vt.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int exp_st[5];
    int n;
    os_all = '1;
    os_b5  = '0;
    os_b5[5] = 1'b1;
    job_valid = 1'b0; ntt_out_start = '0; credit_ret = 1'b0; err_clr = 1'b0;
    #1;

    // Single job: accept at 0, result strobe at 1000.
    do_reset("reset1");
    vt.push_back(v(0,    1, '0, 0, 0, M_RDY|M_SRC|M_STA|M_VAL|M_INF|M_ERR, 1,1,1,0,0,0,0, 0, 4'h0));
    vt.push_back(v(1,    0, '0, 0, 0, M_RDY|M_SRC|M_STA|M_INF|M_BSY,       0,1,0,0,0,0,1, 1, 4'h0));
    vt.push_back(v(63,   0, '0, 0, 0, M_RDY|M_SRC,                         1,1,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(64,   0, '0, 0, 0, M_RDY|M_SRC|M_INF|M_BSY,             1,0,0,0,0,0,1, 1, 4'h0));
    vt.push_back(v(1000, 0, os_all, 0, 0, M_VAL|M_INF,                     0,0,0,0,0,0,0, 1, 4'h0));
    vt.push_back(v(1001, 0, '0, 0, 0, M_VAL|M_SOP|M_EOP|M_INF|M_BSY,       0,0,0,1,1,0,1, 0, 4'h0));
    vt.push_back(v(1064, 0, '0, 0, 0, M_VAL|M_SOP|M_EOP,                   0,0,0,1,0,1,0, 0, 4'h0));
    vt.push_back(v(1065, 0, '0, 0, 0, M_VAL|M_BSY|M_INF|M_ERR,             0,0,0,0,0,0,0, 0, 4'h0));
    run_table("s1", 1070);
    chk("s1 src_rd count", n_src, 64);
    chk("s1 src_rd first", first_src, 0);
    chk("s1 src_rd last", last_src, 63);
    chk("s1 out_valid count", n_val, 64);
    chk("s1 out_valid first", first_val, 1001);
    chk("s1 out_valid last", last_val, 1064);
    chk("s1 in_start pulses", starts.size(), 1);

    // Back-to-back with job_valid held and no credit return until cycle 260.
    do_reset("reset2");
    jv_hold = 1'b1;
    vt.push_back(v(0,   1, '0, 0, 0, M_RDY|M_STA|M_INF,             1,0,1,0,0,0,0, 0, 4'h0));
    vt.push_back(v(63,  1, '0, 0, 0, M_RDY|M_SRC|M_STA,             1,1,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(64,  1, '0, 0, 0, M_RDY|M_STA|M_INF,             0,0,1,0,0,0,0, 2, 4'h0));
    vt.push_back(v(128, 1, '0, 0, 0, M_STA|M_INF,                   0,0,1,0,0,0,0, 3, 4'h0));
    vt.push_back(v(192, 1, '0, 0, 0, M_STA|M_INF,                   0,0,1,0,0,0,0, 4, 4'h0));
    vt.push_back(v(255, 1, '0, 0, 0, M_RDY|M_SRC,                   0,1,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(256, 1, '0, 0, 0, M_RDY|M_SRC|M_STA|M_BSY|M_INF, 0,0,0,0,0,0,1, 4, 4'h0));
    vt.push_back(v(260, 1, '0, 1, 0, M_RDY,                         0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(261, 1, '0, 0, 0, M_RDY|M_SRC|M_STA,             1,1,1,0,0,0,0, 0, 4'h0));
    vt.push_back(v(262, 1, '0, 0, 0, M_INF|M_ERR,                   0,0,0,0,0,0,0, 5, 4'h0));
    run_table("s2", 300);
    exp_st = '{0, 64, 128, 192, 261};
    chk("s2 job starts", starts.size(), 5);
    for (int i = 0; i < 5 && i < starts.size(); i++)
      chk($sformatf("s2 start%0d cycle", i), starts[i], exp_st[i]);

    // Same-cycle events, spurious/mismatch errors and err_clr priority.
    do_reset("reset3");
    vt.push_back(v(0,   1, '0, 1, 0, M_RDY|M_STA,                  1,0,1,0,0,0,0, 0, 4'h0));
    vt.push_back(v(1,   0, '0, 0, 0, M_ERR|M_INF,                  0,0,0,0,0,0,0, 1, 4'h0));
    vt.push_back(v(5,   0, '0, 1, 0, 0,                            0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(6,   0, '0, 0, 0, M_ERR,                        0,0,0,0,0,0,0, 0, 4'h2));
    vt.push_back(v(10,  0, '0, 0, 1, 0,                            0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(11,  0, '0, 0, 0, M_ERR,                        0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(63,  1, os_all, 0, 0, M_RDY|M_INF,              1,0,0,0,0,0,0, 1, 4'h0));
    vt.push_back(v(64,  0, '0, 0, 0, M_INF|M_VAL|M_SOP|M_STA|M_ERR, 0,0,1,1,1,0,0, 1, 4'h0));
    vt.push_back(v(80,  0, os_all, 0, 0, 0,                        0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(81,  0, '0, 0, 0, M_ERR|M_INF|M_VAL,            0,0,0,1,0,0,0, 1, 4'h4));
    vt.push_back(v(100, 0, '0, 0, 1, 0,                            0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(101, 0, '0, 0, 0, M_ERR,                        0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(127, 0, os_all, 0, 0, M_VAL|M_EOP,              0,0,0,1,0,1,0, 0, 4'h0));
    vt.push_back(v(128, 0, '0, 0, 0, M_VAL|M_SOP|M_INF,            0,0,0,1,1,0,0, 0, 4'h0));
    vt.push_back(v(130, 0, '0, 1, 0, 0,                            0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(131, 0, '0, 0, 0, M_ERR,                        0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(132, 0, '0, 1, 1, 0,                            0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(133, 0, '0, 0, 0, M_ERR,                        0,0,0,0,0,0,0, 0, 4'h2));
    vt.push_back(v(140, 0, os_b5, 0, 0, 0,                         0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(141, 0, '0, 0, 0, M_ERR,                        0,0,0,0,0,0,0, 0, 4'h3));
    vt.push_back(v(191, 0, '0, 0, 0, M_VAL|M_EOP,                  0,0,0,1,0,1,0, 0, 4'h0));
    vt.push_back(v(192, 0, '0, 0, 0, M_VAL,                        0,0,0,0,0,0,0, 0, 4'h0));
    run_table("s3", 200);
    chk("s3 out_valid count", n_val, 128);

    // Out-start with nothing in flight, then watchdog timeout.
    do_reset("reset4");
    vt.push_back(v(0,    0, os_all, 0, 0, M_VAL,             0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(1,    0, '0, 0, 0, M_ERR|M_VAL|M_INF,     0,0,0,0,0,0,0, 0, 4'h4));
    vt.push_back(v(2,    0, '0, 0, 1, 0,                     0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(3,    0, '0, 0, 0, M_ERR,                 0,0,0,0,0,0,0, 0, 4'h0));
    vt.push_back(v(5,    1, '0, 0, 0, M_STA,                 0,0,1,0,0,0,0, 0, 4'h0));
    vt.push_back(v(2052, 0, '0, 0, 0, M_ERR|M_INF,           0,0,0,0,0,0,0, 1, 4'h0));
    vt.push_back(v(2053, 0, '0, 0, 0, M_ERR,                 0,0,0,0,0,0,0, 0, 4'h8));
    run_table("s4", 2060);
    chk("s4 out_valid count", n_val, 0);

    // Asynchronous reset in the middle of feeding (beat 30).
    do_reset("reset5");
    job_valid = 1'b1;
    #1;
    chk("s5 accept ready", job_ready, 1);
    @(posedge clk); #1;
    job_valid = 1'b0;
    repeat (29) begin @(posedge clk); #1; end
    chk("s5 src_rd at beat 30", src_rd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("s5 mid-feed reset");
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("s5 inflight after release", inflight, 0);
    credit_ret = 1'b1;
    @(posedge clk); #1;
    credit_ret = 1'b0;
    chk("s5 credits back to full", err, 4'h2);
    n = 0;
    repeat (1100) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("s5 stray out_valid", n, 0);
    chk("s5 busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
